// File: rtl/rsa_pkg.sv
// Shared types for the RSA job sequencer: FSM state encoding, message width
// and the key record used by the inversion cache.
package rsa_pkg;

  localparam int RSA_WIDTH = 128;
  localparam int MSG_W     = 2 * RSA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_INV_PULSE = 3'd2,
    ST_INV_WAIT  = 3'd3,
    ST_EXP_PULSE = 3'd4,
    ST_EXP_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic [RSA_WIDTH-1:0] p;
    logic [RSA_WIDTH-1:0] q;
    logic                 dir;
  } rsa_key_t;

endpackage

// File: rtl/rsa_phase_timer.sv
// Guard + timeout counters shared by both wait phases of the sequencer.
// The guard masks stale finish levels right after a start pulse.
module rsa_phase_timer #(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic active,
  input  logic finish,
  output logic finish_seen,
  output logic timed_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  logic [GW-1:0] guard_reg;
  logic [TW-1:0] timeout_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_reg   <= '0;
      timeout_reg <= '0;
    end else if (load) begin
      guard_reg   <= GW'(GUARD_CYCLES);
      timeout_reg <= '0;
    end else if (active) begin
      if (guard_reg != '0)
        guard_reg <= guard_reg - GW'(1);
      // Saturate so a stalled phase can never wrap back below the threshold.
      if (timeout_reg != TW'(TIMEOUT_CYCLES))
        timeout_reg <= timeout_reg + TW'(1);
    end
  end

  assign finish_seen = active && (guard_reg == '0) && finish;
  assign timed_out   = active && !finish_seen && (timeout_reg >= TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job sequencer for the RSA control core: pulses the inverter and mod_exp
// starts, waits for their finishes and returns the result; caches the last key.
module rsa_job_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH          = RSA_WIDTH,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [WIDTH-1:0]   job_p,
  input  logic [WIDTH-1:0]   job_q,
  input  logic               job_encrypt_decrypt,
  input  logic [2*WIDTH-1:0] job_msg,
  output logic [WIDTH-1:0]   ctl_p,
  output logic [WIDTH-1:0]   ctl_q,
  output logic               ctl_encrypt_decrypt,
  output logic [2*WIDTH-1:0] ctl_msg_in,
  output logic               ctl_reset_inverter,
  output logic               ctl_reset_mod_exp,
  input  logic               ctl_inverter_finish,
  input  logic               ctl_mod_exp_finish,
  input  logic [2*WIDTH-1:0] ctl_msg_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_msg,
  output logic               res_error
);

  // Module-local key record so the cache compare stays exact for any WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic             dir;
  } key_t;

  seq_state_t state_reg;
  key_t       key_cache_reg;
  logic       key_valid_reg;
  key_t       cur_key;

  logic timer_load;
  logic timer_active;
  logic timer_finish;
  logic finish_seen;
  logic timed_out;

  assign cur_key      = '{p: ctl_p, q: ctl_q, dir: ctl_encrypt_decrypt};
  assign timer_load   = (state_reg == ST_INV_PULSE) || (state_reg == ST_EXP_PULSE);
  assign timer_active = (state_reg == ST_INV_WAIT)  || (state_reg == ST_EXP_WAIT);
  assign timer_finish = (state_reg == ST_INV_WAIT) ? ctl_inverter_finish : ctl_mod_exp_finish;

  rsa_phase_timer #(
    .GUARD_CYCLES   (GUARD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (timer_load),
    .active      (timer_active),
    .finish      (timer_finish),
    .finish_seen (finish_seen),
    .timed_out   (timed_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= ST_IDLE;
      job_ready           <= 1'b0;
      ctl_p               <= '0;
      ctl_q               <= '0;
      ctl_encrypt_decrypt <= 1'b0;
      ctl_msg_in          <= '0;
      ctl_reset_inverter  <= 1'b0;
      ctl_reset_mod_exp   <= 1'b0;
      res_valid           <= 1'b0;
      res_msg             <= '0;
      res_error           <= 1'b0;
      key_cache_reg       <= '0;
      key_valid_reg       <= 1'b0;
    end else begin
      ctl_reset_inverter <= 1'b0;
      ctl_reset_mod_exp  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready           <= 1'b0;
            ctl_p               <= job_p;
            ctl_q               <= job_q;
            ctl_encrypt_decrypt <= job_encrypt_decrypt;
            ctl_msg_in          <= job_msg;
            state_reg           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (key_valid_reg && (cur_key == key_cache_reg)) begin
            ctl_reset_mod_exp <= 1'b1;
            state_reg         <= ST_EXP_PULSE;
          end else begin
            key_valid_reg      <= 1'b0;
            ctl_reset_inverter <= 1'b1;
            state_reg          <= ST_INV_PULSE;
          end
        end
        ST_INV_PULSE: state_reg <= ST_INV_WAIT;
        ST_INV_WAIT: begin
          if (finish_seen) begin
            key_cache_reg     <= cur_key;
            key_valid_reg     <= 1'b1;
            ctl_reset_mod_exp <= 1'b1;
            state_reg         <= ST_EXP_PULSE;
          end else if (timed_out) begin
            res_msg       <= '0;
            res_error     <= 1'b1;
            res_valid     <= 1'b1;
            key_valid_reg <= 1'b0;
            state_reg     <= ST_DONE;
          end
        end
        ST_EXP_PULSE: state_reg <= ST_EXP_WAIT;
        ST_EXP_WAIT: begin
          if (finish_seen) begin
            res_msg   <= ctl_msg_out;
            res_error <= 1'b0;
            res_valid <= 1'b1;
            state_reg <= ST_DONE;
          end else if (timed_out) begin
            // A mod_exp timeout may mean a bad inversion result, so drop the key too.
            res_msg       <= '0;
            res_error     <= 1'b1;
            res_valid     <= 1'b1;
            key_valid_reg <= 1'b0;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Randomized scoreboard bench for rsa_job_sequencer with a reactive model of
// the control core and a key-cache / latency reference model.
module tb_rsa_job_sequencer;
  import rsa_pkg::*;

  localparam int W  = RSA_WIDTH;
  localparam int MW = MSG_W;
  localparam int G  = 2;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [W-1:0]  job_p = '0;
  logic [W-1:0]  job_q = '0;
  logic          job_encrypt_decrypt = 1'b0;
  logic [MW-1:0] job_msg = '0;
  logic [W-1:0]  ctl_p;
  logic [W-1:0]  ctl_q;
  logic          ctl_encrypt_decrypt;
  logic [MW-1:0] ctl_msg_in;
  logic          ctl_reset_inverter;
  logic          ctl_reset_mod_exp;
  logic          ctl_inverter_finish;
  logic          ctl_mod_exp_finish;
  logic [MW-1:0] ctl_msg_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [MW-1:0] res_msg;
  logic          res_error;

  rsa_job_sequencer #(.WIDTH(W), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_p(job_p), .job_q(job_q), .job_encrypt_decrypt(job_encrypt_decrypt), .job_msg(job_msg),
    .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_encrypt_decrypt(ctl_encrypt_decrypt), .ctl_msg_in(ctl_msg_in),
    .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
    .ctl_inverter_finish(ctl_inverter_finish), .ctl_mod_exp_finish(ctl_mod_exp_finish),
    .ctl_msg_out(ctl_msg_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg), .res_error(res_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int d_inv;
    int d_exp;
    bit inv_never;
    bit exp_never;
    bit stale;
  } cfg_t;

  typedef struct {
    logic [MW-1:0] msg;
    bit            err;
    int            lat;
    int            n_inv;
    int            n_exp;
    int            exp_off;
    logic [W-1:0]  p;
    logic [W-1:0]  q;
    logic          dir;
    logic [MW-1:0] min;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  cfg_t cur_cfg = '{d_inv: 2, d_exp: 2, inv_never: 1'b0, exp_never: 1'b0, stale: 1'b0};

  logic [2*W:0] m_key = '0;
  bit           m_valid = 1'b0;

  function automatic logic [MW-1:0] core_fn(input logic [W-1:0] p, input logic [W-1:0] q,
                                            input logic d, input logic [MW-1:0] m);
    logic [MW-1:0] k;
    k = {p, q} ^ m;
    return d ? ~k : (k + MW'(1));
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Reactive model of the control core: finishes at configured offsets into each wait phase.
  initial begin
    int inv_start;
    int exp_start;
    int offs;
    logic [MW-1:0] f;
    inv_start = -1;
    exp_start = -1;
    ctl_inverter_finish = 1'b0;
    ctl_mod_exp_finish = 1'b0;
    ctl_msg_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        inv_start = -1;
        exp_start = -1;
        ctl_inverter_finish = 1'b0;
        ctl_mod_exp_finish = 1'b0;
      end else begin
        if (ctl_reset_inverter) begin inv_start = cyc + 1; exp_start = -1; end
        if (ctl_reset_mod_exp) begin exp_start = cyc + 1; inv_start = -1; end
        f = core_fn(ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in);
        ctl_inverter_finish = (inv_start >= 0) && !cur_cfg.inv_never && (cyc == inv_start + cur_cfg.d_inv);
        ctl_mod_exp_finish = 1'b0;
        ctl_msg_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (exp_start >= 0) begin
          offs = cyc - exp_start;
          if (cur_cfg.stale && offs >= 0 && offs < G) begin
            ctl_mod_exp_finish = 1'b1;
            ctl_msg_out = ~f;
          end else if (!cur_cfg.exp_never && offs == cur_cfg.d_exp) begin
            ctl_mod_exp_finish = 1'b1;
            ctl_msg_out = f;
          end
        end
      end
    end
  end

  // Monitor: tracks pulses per job and checks each result against the scoreboard.
  initial begin
    int acc;
    int n_inv;
    int n_exp;
    int exp_off;
    bit prev_valid;
    logic [MW-1:0] held_msg;
    logic held_err;
    exp_t e;
    acc = 0; n_inv = 0; n_exp = 0; exp_off = -1; prev_valid = 1'b0;
    held_msg = '0; held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 1'b0;
        n_inv = 0;
        n_exp = 0;
      end else begin
        if (job_valid && job_ready) begin
          acc = cyc; n_inv = 0; n_exp = 0; exp_off = -1;
        end
        if (ctl_reset_inverter || ctl_reset_mod_exp)
          chk_i("pulse_overlap", int'(ctl_reset_inverter) + int'(ctl_reset_mod_exp), 1);
        if (ctl_reset_inverter) n_inv++;
        if (ctl_reset_mod_exp) begin n_exp++; exp_off = cyc - acc; end
        if (res_valid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            bad++; total++;
            $display("FAIL unexpected_result: got res_valid expected none");
          end else begin
            e = sb_q.pop_front();
            chk("res_msg", res_msg, e.msg);
            chk_i("res_error", int'(res_error), int'(e.err));
            chk_i("latency", cyc - acc, e.lat);
            chk_i("inv_pulses", n_inv, e.n_inv);
            chk_i("exp_pulses", n_exp, e.n_exp);
            if (e.n_exp > 0) chk_i("exp_pulse_offset", exp_off, e.exp_off);
            chk("ctl_pq", MW'({ctl_p, ctl_q}), MW'({e.p, e.q}));
            chk("ctl_msg_in", ctl_msg_in, e.min);
            chk_i("ctl_dir", int'(ctl_encrypt_decrypt), int'(e.dir));
            $display("result: msg=%h err=%0d lat=%0d inv=%0d exp=%0d", res_msg, res_error, cyc - acc, n_inv, n_exp);
          end
          held_msg = res_msg;
          held_err = res_error;
        end else if (res_valid) begin
          chk("res_msg_stable", res_msg, held_msg);
          chk_i("res_error_stable", int'(res_error), int'(held_err));
          chk_i("job_ready_in_done", int'(job_ready), 0);
        end
        prev_valid = res_valid;
      end
    end
  end

  task automatic offer(input logic [W-1:0] p, input logic [W-1:0] q, input logic d, input logic [MW-1:0] m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (job_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      bad++; total++;
      $display("FAIL job_ready_wait: got 0 expected 1 within 100 cycles");
      finish_run();
    end
    job_p = p; job_q = q; job_encrypt_decrypt = d; job_msg = m;
    job_valid = 1'b1;
    @(posedge clk); #2;
    job_valid = 1'b0;
  endtask

  task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic d,
                         input logic [MW-1:0] m, input cfg_t c, input int hold);
    exp_t e;
    bit hit;
    bit ok;
    int exp_pulse;
    hit = m_valid && (m_key == {p, q, d});
    e.p = p; e.q = q; e.dir = d; e.min = m;
    e.n_inv = hit ? 0 : 1;
    e.n_exp = 0; e.exp_off = -1;
    exp_pulse = 2;
    if (!hit) begin
      m_valid = 1'b0;
      exp_pulse = 4 + c.d_inv;
    end
    if (!hit && c.inv_never) begin
      e.err = 1'b1; e.msg = '0; e.lat = 3 + T;
    end else begin
      if (!hit) begin m_key = {p, q, d}; m_valid = 1'b1; end
      e.n_exp = 1; e.exp_off = exp_pulse;
      if (c.exp_never) begin
        e.err = 1'b1; e.msg = '0; e.lat = exp_pulse + 1 + T; m_valid = 1'b0;
      end else begin
        e.err = 1'b0; e.msg = core_fn(p, q, d, m); e.lat = exp_pulse + 2 + c.d_exp;
      end
    end
    sb_q.push_back(e);
    cur_cfg = c;
    offer(p, q, d, m);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (!ok) begin
      bad++; total++;
      $display("FAIL res_valid_wait: got 0 expected 1 within 200 cycles");
      finish_run();
    end
    repeat (hold) @(posedge clk);
    #2 res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0;
    chk_i("res_valid_drop", int'(res_valid), 0);
    chk_i("job_ready_after", int'(job_ready), 1);
  endtask

  task automatic reset_mid_exp(input logic [W-1:0] p, input logic [W-1:0] q, input logic d, input logic [MW-1:0] m);
    bit ok;
    cur_cfg = '{d_inv: 3, d_exp: 2, inv_never: 1'b0, exp_never: 1'b1, stale: 1'b0};
    offer(p, q, d, m);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (ctl_reset_mod_exp) begin ok = 1'b1; break; end
    end
    chk_i("reset_test_exp_pulse", int'(ok), 1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk_i("async_rst_job_ready", int'(job_ready), 0);
    chk("async_rst_ctl_pq", MW'({ctl_p, ctl_q}), '0);
    chk("async_rst_ctl_msg_in", ctl_msg_in, '0);
    chk_i("async_rst_ctl_bits", int'({ctl_encrypt_decrypt, ctl_reset_inverter, ctl_reset_mod_exp}), 0);
    chk_i("async_rst_res", int'({res_valid, res_error}), 0);
    chk("async_rst_res_msg", res_msg, '0);
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0]  p1, q1, p2, q2;
    logic [W-1:0]  kp[3];
    logic [W-1:0]  kq[3];
    cfg_t          c;
    int            k;
    logic          d;
    logic [MW-1:0] m;
    p1 = 128'd113680897410347;
    q1 = 128'd7999808077935876437321;
    p2 = {$urandom, $urandom, $urandom, $urandom};
    q2 = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(posedge clk);
    #2;
    chk_i("reset_job_ready", int'(job_ready), 0);
    chk_i("reset_res", int'({res_valid, res_error, ctl_reset_inverter, ctl_reset_mod_exp}), 0);
    chk("reset_res_msg", res_msg, '0);
    chk("reset_ctl_pq", MW'({ctl_p, ctl_q}), '0);
    reset_n = 1'b1;

    // Miss, hit, stale finish, finish on the timeout boundary.
    run_job(p1, q1, 1'b0, 256'h57e7e100, '{3, 4, 1'b0, 1'b0, 1'b0}, 0);
    run_job(p1, q1, 1'b0, 256'h3c00,     '{3, 2, 1'b0, 1'b0, 1'b0}, 0);
    run_job(p1, q1, 1'b0, 256'h1234,     '{3, 5, 1'b0, 1'b0, 1'b1}, 1);
    run_job(p1, q1, 1'b0, 256'h9999,     '{3, T-1, 1'b0, 1'b0, 1'b0}, 0);
    // Inverter timeout, then the same key must re-run the inverter.
    run_job(p2, q2, 1'b1, 256'hbeef,     '{3, 4, 1'b1, 1'b0, 1'b0}, 0);
    run_job(p2, q2, 1'b1, 256'hbeef,     '{T-1, 2, 1'b0, 1'b0, 1'b0}, 0);
    // Backpressure, then mod_exp timeout clearing the cache.
    run_job(p2, q2, 1'b1, 256'hcafe,     '{3, 6, 1'b0, 1'b0, 1'b0}, 10);
    run_job(p2, q2, 1'b1, 256'hf00d,     '{3, 6, 1'b0, 1'b1, 1'b0}, 0);
    run_job(p2, q2, 1'b1, 256'hf00d,     '{2, 3, 1'b0, 1'b0, 1'b0}, 0);
    // Asynchronous reset during EXP_WAIT; cache must be cold afterwards.
    run_job(p1, q1, 1'b0, 256'h77,       '{3, 4, 1'b0, 1'b0, 1'b0}, 0);
    reset_mid_exp(p1, q1, 1'b0, 256'h88);
    run_job(p1, q1, 1'b0, 256'h88,       '{4, 4, 1'b0, 1'b0, 1'b0}, 0);

    for (int i = 0; i < 3; i++) begin
      kp[i] = {$urandom, $urandom, $urandom, $urandom};
      kq[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    d = 1'b0;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) d = ~d;
      m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      c.d_inv = $urandom_range(G, T-1);
      c.d_exp = $urandom_range(G, T-1);
      c.inv_never = ($urandom_range(0, 9) == 0);
      c.exp_never = ($urandom_range(0, 9) == 0);
      c.stale = ($urandom_range(0, 3) == 0);
      run_job(kp[k], kq[k], d, m, c, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk_i("scoreboard_empty", sb_q.size(), 0);
    finish_run();
  end

endmodule
